// File: rtl/debounce_pkg.sv
// Shared defaults for the debouncer bank and a cycles-to-milliseconds helper
// for sizing debounce/hold windows against the 50 MHz system clock.
package debounce_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_CNT_W  = 18;
    localparam int DEF_HOLD_W = 26;

    localparam longint unsigned CLK_HZ = 64'd50_000_000;

    function automatic int unsigned cycles_to_ms(input longint unsigned cycles);
        longint unsigned ms;
        ms = (cycles * 64'd1000) / CLK_HZ;
        return ms[31:0];
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-FF synchroniser, stability counter, debounced level,
// press/release edge pulses and a saturating long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HOLD_W     = DEF_HOLD_W,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pb_state,
    output logic pb_press,
    output logic pb_release,
    output logic pb_long
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic              sync0_q, sync0_d;
    logic              sync1_q, sync1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              state_q, state_d;
    logic              state_dly_q, state_dly_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;
    logic              idle_s;

    // Next-state logic for synchroniser, debounce window, edge and hold detection
    always_comb begin
        sync0_d     = pb_in ^ ACTIVE_LOW;
        sync1_d     = sync0_q;
        idle_s      = (state_q == sync1_q);
        cnt_d       = '0;
        state_d     = state_q;
        if (idle_s) begin
            cnt_d   = '0;
            state_d = state_q;
        end else begin
            // Counter wraps to zero on the same edge the level is accepted
            cnt_d = cnt_q + CNT_ONE;
            if (&cnt_q) begin
                state_d = ~state_q;
            end else begin
                state_d = state_q;
            end
        end

        state_dly_d = state_q;
        press_d     = state_q & ~state_dly_q;
        release_d   = ~state_q & state_dly_q;

        hold_d = '0;
        if (state_q) begin
            if (&hold_q) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + HOLD_ONE;
            end
        end else begin
            hold_d = '0;
        end
        // Fires only on the step into saturation, so once per press
        long_d = (&hold_d) & ~(&hold_q);
    end

    // State registers; reset returns everything to "released" with no progress kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q     <= 1'b0;
            sync1_q     <= 1'b0;
            cnt_q       <= '0;
            state_q     <= 1'b0;
            state_dly_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= '0;
            long_q      <= 1'b0;
        end else begin
            sync0_q     <= sync0_d;
            sync1_q     <= sync1_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            state_dly_q <= state_dly_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
            long_q      <= long_d;
        end
    end

    assign pb_state   = state_q;
    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign pb_long    = long_q;

endmodule

// File: rtl/debouncer_bank.sv
// Bank of N independent debounced button channels sharing one clock and reset.
module debouncer_bank
    import debounce_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HOLD_W     = DEF_HOLD_W,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] pb_state,
    output logic [N-1:0] pb_press,
    output logic [N-1:0] pb_release,
    output logic [N-1:0] pb_long
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .HOLD_W     (HOLD_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .pb_in      (pb_in[g]),
            .pb_state   (pb_state[g]),
            .pb_press   (pb_press[g]),
            .pb_release (pb_release[g]),
            .pb_long    (pb_long[g])
        );
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank (N=4, CNT_W=4, HOLD_W=6, active-low inputs);
// every output is checked on every cycle against hand-derived expectations.
module tb_debouncer_bank;
    import debounce_pkg::*;

    localparam int N      = 4;
    localparam int CNT_W  = 4;
    localparam int HOLD_W = 6;
    // Edges from the sampling edge until the edge before pb_state changes
    localparam int SETTLE = 17;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pb_in;
    logic [N-1:0] pb_state, pb_press, pb_release, pb_long;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debouncer_bank #(
        .N          (N),
        .CNT_W      (CNT_W),
        .HOLD_W     (HOLD_W),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pb_in      (pb_in),
        .pb_state   (pb_state),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .pb_long    (pb_long)
    );

    task automatic check_out(input string tag, input logic [3:0] st, input logic [3:0] pr,
                             input logic [3:0] rl, input logic [3:0] lg);
        checks++;
        assert ({pb_state, pb_press, pb_release, pb_long} === {st, pr, rl, lg}) else begin
            errors++;
            $error("FAIL %s t=%0t: got state=%b press=%b release=%b long=%b, expected state=%b press=%b release=%b long=%b",
                   tag, $time, pb_state, pb_press, pb_release, pb_long, st, pr, rl, lg);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [3:0] st, input logic [3:0] pr,
                            input logic [3:0] rl, input logic [3:0] lg);
        tick();
        check_out(tag, st, pr, rl, lg);
    endtask

    task automatic idle_steps(input string tag, input int n, input logic [3:0] st);
        for (int i = 0; i < n; i++) begin
            step_chk(tag, st, 4'b0000, 4'b0000, 4'b0000);
        end
    endtask

    // Input already changed: old level for SETTLE edges, new level on the next, pulse one edge later
    task automatic expect_transition(input string tag, input logic [3:0] old_st, input logic [3:0] new_st);
        idle_steps({tag, "_wait"}, SETTLE, old_st);
        step_chk({tag, "_level"}, new_st, 4'b0000, 4'b0000, 4'b0000);
        step_chk({tag, "_pulse"}, new_st, new_st & ~old_st, old_st & ~new_st, 4'b0000);
    endtask

    initial begin
        $display("default debounce window at 50 MHz: %0d ms", cycles_to_ms(64'd262144));

        // Reset held with all buttons pressed
        rst_n = 1'b1;
        pb_in = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        check_out("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step_chk("reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        rst_n = 1'b1;
        expect_transition("reset_exit_press", 4'b0000, 4'b1111);
        pb_in = 4'b1111;
        expect_transition("release_all", 4'b1111, 4'b0000);
        idle_steps("quiet0", 4, 4'b0000);

        // Clean press and release on ch0
        pb_in = 4'b1110;
        expect_transition("ch0_press", 4'b0000, 4'b0001);
        pb_in = 4'b1111;
        expect_transition("ch0_release", 4'b0001, 4'b0000);
        idle_steps("quiet1", 4, 4'b0000);

        // Bounce on ch1: five-cycle segments never fill the window
        for (int i = 0; i < 12; i++) begin
            pb_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            idle_steps("ch1_bounce", 5, 4'b0000);
        end
        idle_steps("ch1_after_bounce", 20, 4'b0000);

        // Long press on ch2: rise at edge R, press at R+1, long at R+63
        pb_in = 4'b1011;
        expect_transition("ch2_long_press", 4'b0000, 4'b0100);
        idle_steps("ch2_hold", 61, 4'b0100);
        step_chk("ch2_long_pulse", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        idle_steps("ch2_hold_sat", 119, 4'b0100);
        pb_in = 4'b1111;
        expect_transition("ch2_long_release", 4'b0100, 4'b0000);
        idle_steps("quiet2", 4, 4'b0000);

        // Short hold on ch2: released well before saturation
        pb_in = 4'b1011;
        expect_transition("ch2_short_press", 4'b0000, 4'b0100);
        idle_steps("ch2_short_hold", 28, 4'b0100);
        pb_in = 4'b1111;
        expect_transition("ch2_short_release", 4'b0100, 4'b0000);
        idle_steps("ch2_no_long", 70, 4'b0000);

        // Simultaneous ch0 and ch3
        pb_in = 4'b0110;
        expect_transition("ch03_press", 4'b0000, 4'b1001);
        pb_in = 4'b1111;
        expect_transition("ch03_release", 4'b1001, 4'b0000);
        idle_steps("quiet3", 4, 4'b0000);

        // Reset while ch1 counter sits at 10
        pb_in = 4'b1101;
        idle_steps("ch1_pre_reset", 12, 4'b0000);
        rst_n = 1'b0;
        pb_in = 4'b1111;
        #1;
        check_out("mid_reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step_chk("mid_reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step_chk("mid_reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        idle_steps("post_reset_quiet", 40, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Synchronises and debounces N push-button/switch inputs with selectable input polarity.
- Per channel it adds one-cycle press and release pulses and a long-press pulse.
- Sits between board pins (keys/switches) and the CPU I/O or control logic, in the same clock domain as the CPU.

Parameters:
- N, 4, number of independent channels.
- CNT_W, 18, debounce counter width; debounce time is 2^CNT_W clk cycles (5.2 ms at 50 MHz).
- HOLD_W, 26, long-press counter width; long press fires after 2^HOLD_W - 1 cycles pressed (~1.34 s at 50 MHz).
- ACTIVE_LOW, 1, 1 = raw input is low when pressed (inverted in the first sync stage); 0 = active-high.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pb_in, input, N, raw asynchronous button inputs.
- pb_state, output, N, debounced level per channel; 1 = pressed.
- pb_press, output, N, one-cycle pulse on a debounced 0->1 transition.
- pb_release, output, N, one-cycle pulse on a debounced 1->0 transition.
- pb_long, output, N, one-cycle pulse when a channel has been held for the long-press time.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clears both sync stages to logical "released" (0 after polarity correction).
  - Clears all counters, pb_state, pb_press, pb_release and pb_long to 0.
  - Reset mid-bounce or mid-hold discards all progress; no pulses fire on reset exit.
- Synchroniser: 2-FF chain per channel. sync0 <= pb_in ^ ACTIVE_LOW; sync1 <= sync0.
- Debounce counter, per channel:
  - idle = (pb_state == sync1).
  - If idle, cnt <= 0.
  - Otherwise cnt <= cnt + 1, wrapping modulo 2^CNT_W.
  - When cnt is all-ones and not idle, pb_state toggles on the same edge and cnt wraps to 0.
- Latency: the input must be stable for the whole window. pb_state changes on rising edge 2 + 2^CNT_W counted from the first edge that samples the new level into sync0.
- Glitch rejection: any return to the old level before cnt reaches all-ones returns idle to 1 and clears cnt. No state change, no pulse.
- Edge pulses:
  - pb_press = registered (pb_state rising). It is high for exactly the one cycle after pb_state goes 1.
  - pb_release does the same for the falling transition.
  - The two are never high together on one channel.
- Long press:
  - hold_cnt (HOLD_W bits) clears while pb_state=0.
  - While pb_state=1 it increments and saturates at all-ones.
  - pb_long pulses for one cycle on the edge hold_cnt reaches all-ones. This is exactly once per press, however long the hold.
  - A release before saturation cancels with no pulse.
  - A release on the saturation cycle still produces pb_long. pb_release follows normally.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- All outputs are registered; there are no combinational paths from pb_in to outputs.

Decomposition:
- Package debounce_pkg: default constants (DEF_CNT_W=18, DEF_HOLD_W=26, DEF_N=4) and a helper function for cycles-to-ms at CLK_HZ=50_000_000, used for bench timing.
- Sub-module debounce_channel: one channel holding the sync, debounce counter, state, edge pulses and hold counter. debouncer_bank instantiates N of them in a generate loop.

Test Plan (bench parameters N=4, CNT_W=4, HOLD_W=6, ACTIVE_LOW=1):
- Reset: hold rst_n=0 with pb_in=4'b0000 (all pressed) -> all outputs 0 during reset. After release, pb_state[3:0]=4'b1111 on the 18th edge, with one pb_press pulse per channel.
- Clean press then release on ch0:
  - Drive pb_in[0]=0 (stable) -> pb_state[0]=1 on edge 18; pb_press[0]=1 for one cycle at edge 19.
  - Drive pb_in[0]=1 (stable) -> pb_state[0]=0 after 18 edges, then a one-cycle pb_release[0].
- Bounce rejection on ch1: toggle pb_in[1] every 5 cycles for 60 cycles, then hold high -> pb_state[1] stays 0, no pulses on any output.
- Long press on ch2: hold pb_in[2]=0 for 200 cycles -> pb_press[2] once. pb_long[2] is exactly one pulse, 63 cycles after pb_state[2] rose, and none after.
- Short hold on ch2: release ch2 after 30 cycles pressed -> no pb_long[2]; pb_release[2] once.
- Independence plus reset mid-operation:
  - Press ch0 and ch3 simultaneously -> identical pulse timing on both channels.
  - Assert rst_n=0 at cnt=10 on ch1 -> no pb_state[1] change and no pulses after reset exit while the input is released.
